// File: rtl/csb_master_bridge_if.sv
// Host command/response, CSB request/response and status signals of the CSB master bridge.
interface csb_master_bridge_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [15:0]          cmd_addr;
    logic [31:0]          cmd_wdat;
    logic                 cmd_write;
    logic                 cmd_nposted;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic                 rsp_is_read;
    logic                 rsp_timeout;

    logic                 csb2nvdla_valid;
    logic                 csb2nvdla_ready;
    logic [15:0]          csb2nvdla_addr;
    logic [31:0]          csb2nvdla_wdat;
    logic                 csb2nvdla_write;
    logic                 csb2nvdla_nposted;

    logic                 nvdla2csb_valid;
    logic [31:0]          nvdla2csb_data;
    logic                 nvdla2csb_wr_complete;

    logic                 busy;
    logic                 err_unexpected;
    logic [CNT_WIDTH-1:0] cnt_timeout;
    logic [CNT_WIDTH-1:0] cnt_unexpected;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_is_read, rsp_timeout,
        input  rsp_ready,
        output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        input  csb2nvdla_ready,
        input  nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        output busy, err_unexpected, cnt_timeout, cnt_unexpected
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_is_read, rsp_timeout,
        output rsp_ready,
        input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
        output csb2nvdla_ready,
        output nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        input  busy, err_unexpected, cnt_timeout, cnt_unexpected
    );
endinterface

// File: rtl/csb_master_bridge.sv
// CSB initiator: queues host commands, issues them in order with one outstanding, returns read/np-write responses.
// Push-to-request 2 cycles, response-to-rsp_valid 1 cycle; cmd_ready = !full, request/response held until ready.
module csb_master_bridge #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                dla_csb_clk,
    input  logic                dla_reset_rstn,
    csb_master_bridge_if.master bus
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
    localparam logic [TW-1:0]        TMR_ONE = TW'(1);
    localparam logic [TW-1:0]        TMR_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic        nposted;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

    state_t               r_state, w_state_nxt;
    cmd_t                 r_mem [CMD_DEPTH];
    cmd_t                 r_req;
    cmd_t                 w_cmd_in;
    logic [AW:0]          r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic                 r_cmd_ready;
    logic                 w_push, w_pop, w_empty, w_full_nxt;
    logic                 w_rsp_hit, w_timeout, w_rsp_done, w_unexp;
    logic [TW-1:0]        r_timer;
    logic [31:0]          r_rsp_data;
    logic                 r_rsp_is_read, r_rsp_timeout, r_err;
    logic [CNT_WIDTH-1:0] r_cnt_timeout, r_cnt_unexp;
    logic                 w_unused;

    // Responses are matched by order alone, so the completion flag carries no information here.
    assign w_unused = bus.nvdla2csb_wr_complete;

    assign w_cmd_in   = {bus.cmd_addr, bus.cmd_wdat, bus.cmd_write, bus.cmd_nposted};
    assign w_push     = bus.cmd_valid && r_cmd_ready;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_wr_nxt   = w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
    assign w_rd_nxt   = w_pop  ? r_rd_ptr + PTR_ONE : r_rd_ptr;
    assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
    assign w_unexp    = bus.nvdla2csb_valid && (r_state != S_WAIT);

    always_ff @(posedge dla_csb_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_cmd_in;
    end

    always_ff @(posedge dla_csb_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) r_state <= S_IDLE;
        else                 r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rsp_hit   = 1'b0;
        w_timeout   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = S_REQ;
            end
            S_REQ: if (bus.csb2nvdla_ready)
                w_state_nxt = (r_req.write && !r_req.nposted) ? S_IDLE : S_WAIT;
            S_WAIT: begin
                // A response on the last timer cycle takes priority over the timeout.
                if (bus.nvdla2csb_valid) begin
                    w_rsp_hit   = 1'b1;
                    w_state_nxt = S_RSP;
                end else if (r_timer == TMR_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: if (bus.rsp_ready) begin
                w_rsp_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge dla_csb_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cmd_ready   <= 1'b1;
            r_req         <= '0;
            r_timer       <= '0;
            r_rsp_data    <= '0;
            r_rsp_is_read <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_err         <= 1'b0;
            r_cnt_timeout <= '0;
            r_cnt_unexp   <= '0;
        end else begin
            r_wr_ptr    <= w_wr_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_cmd_ready <= !w_full_nxt;
            r_err       <= w_unexp;
            if (w_pop) r_req <= r_mem[r_rd_ptr[AW-1:0]];
            if (r_state == S_REQ)       r_timer <= '0;
            else if (r_state == S_WAIT) r_timer <= r_timer + TMR_ONE;
            if (w_rsp_hit) begin
                r_rsp_data    <= r_req.write ? 32'h0 : bus.nvdla2csb_data;
                r_rsp_is_read <= !r_req.write;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data    <= 32'h0;
                r_rsp_is_read <= !r_req.write;
                r_rsp_timeout <= 1'b1;
            end else if (w_rsp_done) begin
                r_rsp_data    <= 32'h0;
                r_rsp_is_read <= 1'b0;
                r_rsp_timeout <= 1'b0;
            end
            if (w_timeout && (r_cnt_timeout != '1)) r_cnt_timeout <= r_cnt_timeout + CNT_ONE;
            if (w_unexp && (r_cnt_unexp != '1))     r_cnt_unexp   <= r_cnt_unexp + CNT_ONE;
        end
    end

    assign bus.cmd_ready         = r_cmd_ready;
    assign bus.csb2nvdla_valid   = (r_state == S_REQ);
    assign bus.csb2nvdla_addr    = r_req.addr;
    assign bus.csb2nvdla_wdat    = r_req.wdat;
    assign bus.csb2nvdla_write   = r_req.write;
    assign bus.csb2nvdla_nposted = r_req.nposted;
    assign bus.rsp_valid         = (r_state == S_RSP);
    assign bus.rsp_data          = r_rsp_data;
    assign bus.rsp_is_read       = r_rsp_is_read;
    assign bus.rsp_timeout       = r_rsp_timeout;
    assign bus.busy              = !w_empty || (r_state != S_IDLE);
    assign bus.err_unexpected    = r_err;
    assign bus.cnt_timeout       = r_cnt_timeout;
    assign bus.cnt_unexpected    = r_cnt_unexp;
endmodule

// File: tb/tb_csb_master_bridge.sv
// Directed bench for csb_master_bridge: per-cycle vector table plus hand sequences for backpressure, timeout and reset.
module tb_csb_master_bridge;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_unexp = 0;

    always #5 clk = ~clk;

    csb_master_bridge_if #(.CNT_WIDTH(16)) bus ();

    csb_master_bridge #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
        .dla_csb_clk    (clk),
        .dla_reset_rstn (rst_n),
        .bus            (bus)
    );

    typedef struct {
        logic        cv;
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        wr, np, rrdy, crdy, nvv;
        logic [31:0] nvd;
        logic        e_crdy, e_cv;
        logic [15:0] e_addr;
        logic [31:0] e_wdat;
        logic        e_wr, e_rv;
        logic [31:0] e_rdata;
        logic        e_rrd, e_rto, e_busy, e_err;
    } vec_t;

    vec_t tv [22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid             = 1'b0;
        bus.cmd_addr              = 16'h0;
        bus.cmd_wdat              = 32'h0;
        bus.cmd_write             = 1'b0;
        bus.cmd_nposted           = 1'b0;
        bus.rsp_ready             = 1'b0;
        bus.csb2nvdla_ready       = 1'b0;
        bus.nvdla2csb_valid       = 1'b0;
        bus.nvdla2csb_data        = 32'h0;
        bus.nvdla2csb_wr_complete = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [31:0] d, input logic w, input logic np);
        bus.cmd_valid   = 1'b1;
        bus.cmd_addr    = a;
        bus.cmd_wdat    = d;
        bus.cmd_write   = w;
        bus.cmd_nposted = np;
        step();
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic wait_csb_valid(input string name);
        for (int c = 0; c < 10 && !bus.csb2nvdla_valid; c++) step();
        check(name, 64'(bus.csb2nvdla_valid), 64'h1);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic ok;
        bus.cmd_valid       = v.cv;
        bus.cmd_addr        = v.addr;
        bus.cmd_wdat        = v.wdat;
        bus.cmd_write       = v.wr;
        bus.cmd_nposted     = v.np;
        bus.rsp_ready       = v.rrdy;
        bus.csb2nvdla_ready = v.crdy;
        bus.nvdla2csb_valid = v.nvv;
        bus.nvdla2csb_data  = v.nvd;
        step();
        ok = (bus.cmd_ready === v.e_crdy) && (bus.csb2nvdla_valid === v.e_cv) &&
             (bus.rsp_valid === v.e_rv) && (bus.busy === v.e_busy) && (bus.err_unexpected === v.e_err);
        if (v.e_cv)
            ok = ok && (bus.csb2nvdla_addr === v.e_addr) && (bus.csb2nvdla_wdat === v.e_wdat) &&
                 (bus.csb2nvdla_write === v.e_wr);
        if (v.e_rv)
            ok = ok && (bus.rsp_data === v.e_rdata) && (bus.rsp_is_read === v.e_rrd) &&
                 (bus.rsp_timeout === v.e_rto);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL vec%0d: got rdy=%b cv=%b addr=%h wdat=%h wr=%b rv=%b rdata=%h rd=%b to=%b busy=%b err=%b expected rdy=%b cv=%b addr=%h wdat=%h wr=%b rv=%b rdata=%h rd=%b to=%b busy=%b err=%b",
                     idx, bus.cmd_ready, bus.csb2nvdla_valid, bus.csb2nvdla_addr, bus.csb2nvdla_wdat,
                     bus.csb2nvdla_write, bus.rsp_valid, bus.rsp_data, bus.rsp_is_read, bus.rsp_timeout,
                     bus.busy, bus.err_unexpected, v.e_crdy, v.e_cv, v.e_addr, v.e_wdat, v.e_wr, v.e_rv,
                     v.e_rdata, v.e_rrd, v.e_rto, v.e_busy, v.e_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seen [$];
        logic        pushed6;
        logic        any_v;
        int          n;

        // Posted write 0x1000, then read 0x0004 with backpressure, then np write 0x0008, then a stray response.
        tv[0]  = '{1'b1,16'h1000,32'hA5A55A5A,1'b1,1'b0, 1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[1]  = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,32'h0, 1'b1,1'b1,16'h1000,32'hA5A55A5A,1'b1, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[2]  = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0};
        tv[3]  = tv[2];
        tv[4]  = '{1'b1,16'h0004,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[5]  = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,16'h0004,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[6]  = tv[5];
        tv[7]  = '{1'b1,16'h0008,32'hDEADBEEF,1'b1,1'b1, 1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[8]  = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[9]  = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b1,32'h12345678, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b1,32'h12345678,1'b1,1'b0, 1'b1,1'b0};
        for (int i = 10; i < 15; i++)
            tv[i] = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b1,32'h12345678,1'b1,1'b0, 1'b1,1'b0};
        tv[15] = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b1,1'b1,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[16] = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b0,32'h0, 1'b1,1'b1,16'h0008,32'hDEADBEEF,1'b1, 1'b0,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[17] = tv[8];
        tv[18] = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b1,32'hFFFFFFFF, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b1,32'h0,1'b0,1'b0, 1'b1,1'b0};
        tv[19] = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b1,1'b1,1'b0,32'h0, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b0,1'b0};
        tv[20] = '{1'b0,16'h0,32'h0,1'b0,1'b0, 1'b0,1'b1,1'b1,32'h00000055, 1'b1,1'b0,16'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,1'b0, 1'b0,1'b1};
        tv[21] = tv[2];

        idle_inputs();
        repeat (3) step();
        check("rst_state", {bus.cmd_ready, bus.csb2nvdla_valid, bus.rsp_valid, bus.busy, bus.err_unexpected,
                            bus.cnt_timeout, bus.cnt_unexpected}, {1'b1, 4'b0, 32'h0});
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 22; i++) apply_vec(tv[i], i);
        exp_unexp = 1;
        check("cnt_unexp_tbl", 64'(bus.cnt_unexpected), 64'(exp_unexp));
        idle_inputs();
        step();

        // Backpressure: five posted writes with the CSB side stalled.
        for (int i = 0; i < 5; i++) begin
            check("bp_rdy", 64'(bus.cmd_ready), 64'h1);
            push(16'h0100 + 16'(i), 32'hC0DE0000 + 32'(i), 1'b1, 1'b0);
        end
        check("bp_full", 64'(bus.cmd_ready), 64'h0);
        check("bp_head", {bus.csb2nvdla_valid, bus.csb2nvdla_addr}, {1'b1, 16'h0100});
        bus.cmd_valid = 1'b1; bus.cmd_addr = 16'h0105; bus.cmd_wdat = 32'hC0DE0005;
        bus.cmd_write = 1'b1; bus.cmd_nposted = 1'b0;
        bus.csb2nvdla_ready = 1'b1;
        pushed6 = 1'b0;
        for (int c = 0; c < 60 && seen.size() < 6; c++) begin
            if (bus.csb2nvdla_valid) seen.push_back(bus.csb2nvdla_addr);
            if (bus.cmd_valid && bus.cmd_ready) pushed6 = 1'b1;
            step();
            if (pushed6) bus.cmd_valid = 1'b0;
        end
        check("bp_count", 64'(seen.size()), 64'd6);
        for (int k = 0; k < seen.size(); k++) check("bp_order", 64'(seen[k]), 64'(16'h0100 + 16'(k)));
        step();
        check("bp_drained", {bus.csb2nvdla_valid, bus.busy}, 64'h0);

        // Non-posted write that never completes, then a late response.
        push(16'h0200, 32'h11112222, 1'b1, 1'b1);
        wait_csb_valid("to_issue");
        step();
        n = 0;
        while (n < 20 && !bus.rsp_valid) begin
            step();
            n++;
        end
        check("to_latency", 64'(n), 64'd8);
        check("to_flags", {bus.rsp_timeout, bus.rsp_is_read, bus.rsp_data}, {1'b1, 1'b0, 32'h0});
        check("to_cnt", 64'(bus.cnt_timeout), 64'd1);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'hBEEF0000;
        step();
        bus.nvdla2csb_valid = 1'b0;
        exp_unexp++;
        check("late_err", 64'(bus.err_unexpected), 64'h1);
        check("late_cnt", 64'(bus.cnt_unexpected), 64'(exp_unexp));

        // Read whose response lands exactly on the final timeout cycle.
        push(16'h0300, 32'h0, 1'b0, 1'b0);
        wait_csb_valid("edge_issue");
        step();
        repeat (7) step();
        check("edge_pre", 64'(bus.rsp_valid), 64'h0);
        bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'h0BADF00D; bus.nvdla2csb_wr_complete = 1'b0;
        step();
        bus.nvdla2csb_valid = 1'b0;
        check("edge_rsp", {bus.rsp_valid, bus.rsp_timeout, bus.rsp_is_read, bus.rsp_data}, {1'b1, 1'b0, 1'b1, 32'h0BADF00D});
        check("edge_cnt", {bus.cnt_timeout, bus.err_unexpected}, {16'd1, 1'b0});
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        // Reset while waiting for a response with three commands queued.
        push(16'h0400, 32'h0, 1'b0, 1'b0);
        wait_csb_valid("rst_issue");
        step();
        for (int i = 0; i < 3; i++) push(16'h0500 + 16'(i), 32'h0, 1'b0, 1'b0);
        check("rst_pre_busy", {bus.busy, bus.csb2nvdla_valid}, {1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid", {bus.cmd_ready, bus.csb2nvdla_valid, bus.rsp_valid, bus.busy, bus.err_unexpected,
                          bus.cnt_timeout, bus.cnt_unexpected, bus.csb2nvdla_addr, bus.rsp_data[15:0]},
              {1'b1, 4'b0, 32'h0, 16'h0, 16'h0});
        step();
        rst_n = 1'b1;
        any_v = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            any_v = any_v | bus.csb2nvdla_valid | bus.busy;
        end
        check("rst_quiet", 64'(any_v), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
